// File: rtl/microgreen_scan_scheduler_if.sv
// Host/classifier handshake bundle for microgreen_scan_scheduler.
//   Host side:       start, abort, tray_mask -> ; <- ready_map, scan_done, busy, timeout_err
//   Classifier side: <- tray_sel, cls_start ; cls_done, cls_result ->
// slave  : the scheduler itself
// master : whatever drives the scheduler (host + sensor mux + classifier)
interface microgreen_scan_scheduler_if #(
  parameter int NUM_TRAYS = 4
) ();
  localparam int SEL_W = $clog2(NUM_TRAYS);

  logic                 start;
  logic                 abort;
  logic [NUM_TRAYS-1:0] tray_mask;
  logic [SEL_W-1:0]     tray_sel;
  logic                 cls_start;
  logic                 cls_done;
  logic                 cls_result;
  logic [NUM_TRAYS-1:0] ready_map;
  logic                 scan_done;
  logic                 busy;
  logic                 timeout_err;

  modport slave (
    input  start, abort, tray_mask, cls_done, cls_result,
    output tray_sel, cls_start, ready_map, scan_done, busy, timeout_err
  );

  modport master (
    output start, abort, tray_mask, cls_done, cls_result,
    input  tray_sel, cls_start, ready_map, scan_done, busy, timeout_err
  );
endinterface

// File: rtl/microgreen_scan_scheduler.sv
// Sequences one shared BNN classifier over up to NUM_TRAYS sensor trays.
// Per enabled tray: select mux, settle, run VOTES classifications, majority
// vote into a shadow bitmap; the bitmap is published on ready_map when the
// scan completes.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   ena         : global hold; low freezes all state and masks cls_start
//   bus (slave) : host start/abort/mask/result handshake and classifier
//                 start/done handshake (see microgreen_scan_scheduler_if)
module microgreen_scan_scheduler #(
  parameter int NUM_TRAYS     = 4,
  parameter int VOTES         = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  microgreen_scan_scheduler_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_TRAYS);

  localparam logic [2:0] VOTES_C     = 3'(VOTES);
  localparam logic [3:0] VOTES_X2    = 4'(VOTES);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_LAUNCH, S_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t               state;
  logic [SEL_W-1:0]     sel;
  logic [NUM_TRAYS-1:0] mask_q;
  logic [NUM_TRAYS-1:0] shadow;
  logic [NUM_TRAYS-1:0] ready_q;
  logic                 tmo_err;
  logic                 tray_tmo;   // current tray ended by timeout
  logic [2:0]           vote_cnt;
  logic [2:0]           yes_cnt;
  logic [3:0]           settle_cnt;
  logic [7:0]           to_cnt;

  logic [NUM_TRAYS-1:0] sel_oh;
  logic [NUM_TRAYS-1:0] rem_mask;
  logic [NUM_TRAYS-1:0] shadow_upd;
  logic                 verdict;

  // Lowest set bit of m; trays are visited in ascending index order.
  function automatic logic [SEL_W-1:0] lowest(input logic [NUM_TRAYS-1:0] m);
    lowest = '0;
    for (int i = NUM_TRAYS - 1; i >= 0; i--)
      if (m[i]) lowest = SEL_W'(i);
  endfunction

  always_comb begin
    sel_oh   = NUM_TRAYS'(1) << sel;
    rem_mask = mask_q & ~sel_oh;
    // Strict majority: 2*yes > VOTES. A timed-out tray is never ready.
    verdict  = !tray_tmo && ({yes_cnt, 1'b0} > VOTES_X2);
    shadow_upd = verdict ? (shadow | sel_oh) : (shadow & ~sel_oh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sel        <= '0;
      mask_q     <= '0;
      shadow     <= '0;
      ready_q    <= '0;
      tmo_err    <= 1'b0;
      tray_tmo   <= 1'b0;
      vote_cnt   <= '0;
      yes_cnt    <= '0;
      settle_cnt <= '0;
      to_cnt     <= '0;
    end else if (ena) begin
      if (bus.abort && state != S_IDLE) begin
        // Abort drops the scan without touching the published results.
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (bus.start && !bus.abort) begin
            mask_q     <= bus.tray_mask;
            shadow     <= '0;
            tmo_err    <= 1'b0;
            tray_tmo   <= 1'b0;
            vote_cnt   <= '0;
            yes_cnt    <= '0;
            settle_cnt <= '0;
            sel        <= lowest(bus.tray_mask);
            // Empty mask falls through NEXT so ready_map is published as 0.
            state      <= (bus.tray_mask == '0) ? S_NEXT : S_SELECT;
          end
          S_SELECT: begin
            vote_cnt <= '0;
            yes_cnt  <= '0;
            tray_tmo <= 1'b0;
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              state      <= S_LAUNCH;
            end else begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end
          S_LAUNCH: begin
            to_cnt <= '0;
            state  <= S_WAIT;
          end
          S_WAIT: begin
            // cls_done is checked first so a result on the expiry cycle counts.
            if (bus.cls_done) begin
              yes_cnt  <= yes_cnt + {2'b00, bus.cls_result};
              vote_cnt <= vote_cnt + 3'd1;
              state    <= (vote_cnt + 3'd1 == VOTES_C) ? S_NEXT : S_LAUNCH;
            end else if (to_cnt == TMO_LAST) begin
              tmo_err  <= 1'b1;
              tray_tmo <= 1'b1;
              state    <= S_NEXT;
            end else begin
              to_cnt <= to_cnt + 8'd1;
            end
          end
          S_NEXT: begin
            shadow <= shadow_upd;
            mask_q <= rem_mask;
            if (|rem_mask) begin
              sel        <= lowest(rem_mask);
              settle_cnt <= '0;
              state      <= S_SELECT;
            end else begin
              ready_q <= shadow_upd;
              state   <= S_DONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.tray_sel    = sel;
  assign bus.cls_start   = (state == S_LAUNCH) && ena;
  assign bus.scan_done   = (state == S_DONE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.ready_map   = ready_q;
  assign bus.timeout_err = tmo_err;
endmodule
